// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and RAM-side signal bundle for mem_arbiter
interface mem_arbiter_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 10
);
    // port 0: instruction fetch
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0;
    logic              rvalid0;
    logic [DATA_W-1:0] rdata0;

    // port 1: data load/store
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata1;

    // single-port RAM side
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // arbiter view
    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rdata,
        output gnt0, rvalid0, rdata0,
        output gnt1, rvalid1, rdata1,
        output mem_we, mem_addr, mem_wdata
    );

    // requesters plus RAM view
    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rdata,
        input  gnt0, rvalid0, rdata0,
        input  gnt1, rvalid1, rdata1,
        input  mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter for a single-port RAM (option: MEMARB_FIXED_PRIO_EN)
module mem_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 10
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic              id_q, id_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              tie_winner;
    logic              win;

    // Tie-break when both ports request in the same IDLE cycle
`ifdef MEMARB_FIXED_PRIO_EN
    assign tie_winner = 1'b1;
`else
    assign tie_winner = ~last_q;
`endif

    // State and latched-request registers; reset abandons any access in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Arbitration and next-state: latch the winner in IDLE, then one ISSUE and optional RESP cycle
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        win     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    if (bus.req0 && bus.req1) begin
                        win = tie_winner;
                    end else begin
                        win = bus.req1;
                    end
                    id_d    = win;
                    last_d  = win;
                    we_d    = win ? bus.we1    : bus.we0;
                    addr_d  = win ? bus.addr1  : bus.addr0;
                    wdata_d = win ? bus.wdata1 : bus.wdata0;
                    state_d = ISSUE;
                end
            end
            ISSUE:   state_d = we_q ? IDLE : RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state; RAM address/data simply hold the last latched request
    always_comb begin
        logic issue;
        logic resp;
        issue         = (state_q == ISSUE);
        resp          = (state_q == RESP);
        bus.gnt0      = issue && !id_q;
        bus.gnt1      = issue &&  id_q;
        bus.mem_we    = issue && we_q;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.rvalid0   = resp && !id_q;
        bus.rvalid1   = resp &&  id_q;
        bus.rdata0    = (resp && !id_q) ? bus.mem_rdata : '0;
        bus.rdata1    = (resp &&  id_q) ? bus.mem_rdata : '0;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port 64x10 block RAM between two CPU requesters: port 0 (instruction fetch) and port 1 (data load/store).
- Sequences each access through a small FSM and arbitrates round-robin.
- Drives the RAM's write-enable, address and write-data inputs.
- Returns the RAM's 1-cycle-latency read data to the winning port with a valid strobe.

Parameters:
- ADDR_W, 6, address width; RAM depth is 2**ADDR_W.
- DATA_W, 10, data word width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req0  in  1  port 0 access request.
- we0  in  1  port 0 write (1) / read (0).
- addr0  in  ADDR_W  port 0 address.
- wdata0  in  DATA_W  port 0 write data.
- gnt0  out  1  port 0 grant pulse.
- rvalid0  out  1  port 0 read data valid.
- rdata0  out  DATA_W  port 0 read data.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM registered read data.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, last=1 (so port 0 wins the first tie).
  - gnt0/1=0, rvalid0/1=0, mem_we=0, mem_addr=0, mem_wdata=0, latched request regs=0.
  - Reset mid-access abandons the access; mem_we drops immediately, and no write occurs after reset asserts.
- Requester rule: hold req/we/addr/wdata stable from raising req until the cycle gnt is seen high. Deassert or change them the cycle after gnt.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If neither req is set, stay in IDLE.
  - If exactly one req is set, that port wins.
  - If both are set, the port != last wins.
  - On a win, latch the winner's id, we, addr and wdata, set last=winner, and go to ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_addr=latched addr, mem_wdata=latched wdata, mem_we=latched we.
  - gnt of the winner =1; the other gnt =0.
  - Next state: read goes to RESP; write goes to IDLE.
- RESP (exactly 1 cycle):
  - mem_we=0; rvalid of the winner =1.
  - The winner's rdata = mem_rdata (combinational pass-through).
  - Next state: IDLE.
- Outputs outside these states:
  - mem_we=0 in IDLE and RESP.
  - mem_addr/mem_wdata hold their last value.
  - rdataN is 0 whenever rvalidN=0.
- Latency, measured from the first cycle req is seen in IDLE (t):
  - read: gnt at t+1, rvalid/rdata at t+2, next arbitration at t+3.
  - write: gnt at t+1, RAM written at the end of t+1, next arbitration at t+2.
- Throughput: 1 read per 3 cycles, 1 write per 2 cycles.
- The loser's req is not cleared and is serviced at the next IDLE.
- With both ports requesting continuously, grants alternate 0,1,0,1...
- The same port requesting back-to-back alone is granted every time; there is no starvation condition.
- Reads and writes of the same address: a read issued after a completed write returns the new data. No write-forwarding is needed because accesses are serialized.
- No other X propagation: the we/addr/wdata of a port with req=0 are ignored.

Optional Feature:
- Macro: MEMARB_FIXED_PRIO_EN.
- Defined: tie-break is fixed priority, and port 1 (data) always wins when both request.
  - `last` is still updated but unused.
  - Port 0 can starve while req1 is held.
- Undefined: round-robin as specified above.

Test Plan:
- Reset, idle: rst=0 then 1, no reqs -> all outputs 0 for 10 cycles, state IDLE.
- Port 1 write then port 0 read:
  - req1, we1=1, addr1=6'h05, wdata1=10'h2A5 -> gnt1 at t+1 with mem_we=1, mem_addr=5.
  - Then req0 read of addr 5 -> gnt0 one cycle after it is seen, rvalid0 one cycle later, rdata0=10'h2A5.
- Simultaneous requests from reset:
  - Both ports read (addr0=0, addr1=1), held until granted -> gnt0 first, gnt1 three cycles later.
  - Each sees rvalid with the correct word; continuous requests alternate 0,1,0,1.
- Write throughput: port 0 writes addrs 0..3 back-to-back -> gnt0 every 2 cycles; a readback of 0..3 returns the written values.
- Reset mid-access: assert rst during the ISSUE of a write to addr 6'h3F -> mem_we falls immediately, gnt0/1=0; after release, addr 6'h3F holds its old value and state is IDLE.
- MEMARB_FIXED_PRIO_EN defined, both ports requesting continuously -> only gnt1 pulses; gnt0 after req1 drops.
